// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result selects, load types and the link offset.
package wb_pkg;

  typedef enum logic [2:0] {
    SEL_ALU   = 3'd0,
    SEL_LOAD  = 3'd1,
    SEL_SHIFT = 3'd2,
    SEL_LINK  = 3'd3,
    SEL_HILO  = 3'd4
  } sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_e;

  localparam int unsigned PC_LINK_OFFSET = 8;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load aligner: picks the addressed byte/half of the loaded word and extends it.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] dm_i,
  input  logic [2:0]        ld_type_i,
  input  logic [1:0]        addr_lo_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dm_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = dm_i[7:0];
      2'd1:    byte_sel = dm_i[15:8];
      2'd2:    byte_sel = dm_i[23:16];
      default: byte_sel = dm_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? dm_i[31:16] : dm_i[15:0];
  end

  always_comb begin
    ext_o = dm_i;
    case (ld_type_i)
      LD_W:    ext_o = dm_i;
      LD_B:    ext_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ext_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    ext_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   ext_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext_o = dm_i;
    endcase
  end

endmodule

// File: rtl/wb_arb_stage.sv
// Registered writeback stage arbitrating the register-file write port between pipeline and MDU.
// Optional simulation trace of every register write when WB_TRACE_EN is defined.
module wb_arb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [DATA_W-1:0]     m_pc,
  input  logic                  m_regw,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic [SEL_W-1:0]      m_sel,
  input  logic [DATA_W-1:0]     m_alu,
  input  logic [DATA_W-1:0]     m_dm,
  input  logic [DATA_W-1:0]     m_shift,
  input  logic [DATA_W-1:0]     m_hilo,
  input  logic [2:0]            m_ld_type,
  input  logic [1:0]            m_addr_lo,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic                  w_we,
  output logic [REG_ADDR_W-1:0] w_waddr,
  output logic [DATA_W-1:0]     w_wdata,
  output logic [DATA_W-1:0]     w_pc,
  output logic                  w_src
);

  localparam int unsigned CntW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic                  full_q, full_d;
  logic [DATA_W-1:0]     pc_q;
  logic                  regw_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     data_q;
  logic [CntW-1:0]       starve_q, starve_d;

  logic [DATA_W-1:0]     ld_ext;
  logic [DATA_W-1:0]     res_d;
  logic                  starve_hit;
  logic                  pipe_gnt;
  logic                  mdu_gnt;
  logic                  load;

  wb_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .dm_i      (m_dm),
    .ld_type_i (m_ld_type),
    .addr_lo_i (m_addr_lo),
    .ext_o     (ld_ext)
  );

  always_comb begin
    res_d = '0;
    case (m_sel)
      SEL_W'(SEL_ALU):   res_d = m_alu;
      SEL_W'(SEL_LOAD):  res_d = ld_ext;
      SEL_W'(SEL_SHIFT): res_d = m_shift;
      SEL_W'(SEL_LINK):  res_d = m_pc + DATA_W'(PC_LINK_OFFSET);
      SEL_W'(SEL_HILO):  res_d = m_hilo;
      default:           res_d = '0;
    endcase
  end

  // MDU grant is also gated by reset so the port is silent while reset is held.
  assign starve_hit = (starve_q == Limit);
  assign pipe_gnt   = full_q && !(mdu_valid && starve_hit);
  assign mdu_gnt    = reset_n && mdu_valid && (!full_q || starve_hit);
  assign m_ready    = !full_q || pipe_gnt;
  assign mdu_ready  = mdu_gnt;
  assign load       = m_valid && m_ready;

  always_comb begin
    full_d = full_q;
    if (load) begin
      full_d = 1'b1;
    end else if (pipe_gnt) begin
      full_d = 1'b0;
    end

    starve_d = starve_q;
    if (!mdu_valid || mdu_gnt) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 1'b0;
      pc_q     <= '0;
      regw_q   <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      full_q   <= full_d;
      starve_q <= starve_d;
      if (load) begin
        pc_q   <= m_pc;
        regw_q <= m_regw;
        rd_q   <= m_rd;
        data_q <= res_d;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_pc    = '0;
    w_src   = 1'b0;
    if (mdu_gnt) begin
      w_we    = (mdu_rd != '0);
      w_waddr = mdu_rd;
      w_wdata = mdu_data;
      w_src   = 1'b1;
    end else if (pipe_gnt) begin
      w_we    = regw_q && (rd_q != '0);
      w_waddr = rd_q;
      w_wdata = data_q;
      w_pc    = pc_q;
    end
  end

`ifdef WB_TRACE_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt_q <= '0;
    end else if (pipe_gnt || mdu_gnt) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_we) begin
      $display("@%08h: $%0d <= %08h  [retire %0d]", w_pc, w_waddr, w_wdata,
               retire_cnt_q + 32'd1);
    end
  end
`else
  // Trace disabled: no retire counter and no output.
`endif

endmodule
